// File: rtl/fetch_unit.sv
// fetch_unit
//   Program counter and fetch stage for the 9-bit-instruction core. Presents
//   the PC to a combinational instruction ROM and registers the returned word
//   into the fetch/decode pipeline register. Supports stall, branch redirect
//   with wrong-path squash, start from IDLE and a halt that is sticky until
//   reset.
//
// Ports
//   clk            rising-edge clock
//   reset          synchronous, active-high reset
//   start          one-cycle pulse: IDLE -> RUN
//   stall          downstream not ready; hold PC and IR
//   branch_taken   redirect request from execute
//   branch_target  absolute target PC
//   halt           stop fetching (sticky until reset)
//   rom_addr       ROM address (= current PC)
//   rom_instr      ROM data for rom_addr, same cycle
//   instr_out      registered instruction to decode
//   instr_pc       PC of instr_out
//   instr_valid    instr_out is a real instruction
//   halted         FSM is in HALTED
//   fetch_count    instructions issued, saturating at 16'hFFFF
module fetch_unit #(
  parameter int unsigned          ADDR_W   = 8,
  parameter int unsigned          INSTR_W  = 9,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  input  logic               halt,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [INSTR_W-1:0] rom_instr,
  output logic [INSTR_W-1:0] instr_out,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  output logic               halted,
  output logic [15:0]        fetch_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;

  assign rom_addr = pc;
  assign halted   = (state == HALTED);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      instr_out   <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      fetch_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          instr_valid <= 1'b0;
          if (start) state <= RUN;
        end
        RUN: begin
          if (halt) begin
            state       <= HALTED;
            instr_valid <= 1'b0;
          end else if (branch_taken) begin
            // Redirect squashes the word fetched at the old PC this cycle.
            pc          <= branch_target;
            instr_valid <= 1'b0;
          end else if (!stall) begin
            instr_out   <= rom_instr;
            instr_pc    <= pc;
            instr_valid <= 1'b1;
            pc          <= pc + ADDR_W'(1);
            if (fetch_count != 16'hFFFF) fetch_count <= fetch_count + 16'd1;
          end
        end
        HALTED: begin
          instr_valid <= 1'b0;
        end
        default: begin
          state       <= IDLE;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
